memory_field_reader: RTL
========================

Name: memory_field_reader

Overview:
- Read-side counterpart of the starting-memory packer: snapshots the 48-bit game memory word and streams it out one 8-bit field per transfer over a valid/ready handshake.
- Each field is tagged with its player and field type.
- Feeds the display/UART path and the transaction checker.
- Optionally hides private-key fields and flags any player whose balance is zero.

Parameters:
- NUM_FIELDS, 6, number of 8-bit fields in the memory word (fixed layout; not for resizing).
- HIDE_VALUE, 8'h00, byte substituted for a private key when hiding is enabled.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memory_in  in  48  packed memory: [47:40] p1_private, [39:32] p1_public, [31:24] p1_money, [23:16] p2_private, [15:8] p2_public, [7:0] p2_money.
- start  in  1  single-cycle request to snapshot memory_in and begin streaming.
- hide_private  in  1  sampled with start; 1 = private fields output as HIDE_VALUE.
- out_valid  out  1  out_data/out_player/out_field are valid.
- out_ready  in  1  consumer accepts the current field.
- out_data  out  8  field byte.
- out_player  out  1  0 = player 1, 1 = player 2.
- out_field  out  2  0 = private, 1 = public, 2 = money.
- out_last  out  1  high with the final field (index 5).
- busy  out  1  high from the cycle after start until the last field is accepted.
- done  out  1  one-cycle pulse in the cycle after the last field is accepted.
- broke  out  2  [1] = p2_money==0, [0] = p1_money==0, from the snapshot; held until the next start.

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0, busy=0, done=0, broke=2'b00, out_data=0, out_player=0, out_field=0, out_last=0; snapshot and index cleared.
- FSM states IDLE, LOAD, SEND, FINISH.
- IDLE:
  - start=1 → capture memory_in into the snapshot register and latch hide_private; index=0; go to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle):
  - Compute broke from the snapshot money bytes.
  - Drive field 0 onto the outputs; out_valid=1; go to SEND.
  - First out_valid appears 2 cycles after the start edge.
- SEND:
  - Outputs are registered and stable while out_valid=1 and out_ready=0.
  - Transfer occurs on a rising edge with out_valid & out_ready.
  - After a transfer of index<5: index+1, next field driven in the next cycle, out_valid stays 1. This gives one field per cycle when out_ready is held high.
  - After a transfer of index 5: out_valid=0, go to FINISH.
- Field order, index 0..5: p1_private, p1_public, p1_money, p2_private, p2_public, p2_money.
  - out_player = (index>=3).
  - out_field = index mod 3.
  - out_last = (index==5).
- Hiding: when the latched hide_private=1 and out_field==0, out_data=HIDE_VALUE. Tag outputs are unchanged.
- FINISH (1 cycle): done=1, busy=0; return to IDLE.
  - start in this cycle is ignored.
  - start in the following IDLE cycle is accepted.
- Snapshot isolation: memory_in changes after the start edge do not affect the streamed bytes.
- Reset mid-stream: immediate return to IDLE with all outputs at reset values; no done pulse.
- broke is updated only in LOAD. It holds its value through IDLE, including after done.

Decomposition:
- Shared package/header:
  - field codes FIELD_PRIVATE=0, FIELD_PUBLIC=1, FIELD_MONEY=2;
  - bit-slice constants for the six fields of the 48-bit memory layout, reused by the packer and the checker.
- One natural sub-module, field_select: combinational mux from snapshot + index + hide flag to {data, player, field, last}.
- FSM and handshake registers live in the top.

Test Plan:
- Default memory 48'h75_xx_64_1B_yy_64, out_ready=1, hide=0, start pulse → first valid 2 cycles later. Sequence 75,xx,64,1B,yy,64 with tags (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), out_last only on 6th, done 1 cycle after, broke=00.
- Same stimulus with hide_private=1 → fields 0 and 3 output 00, all others unchanged.
- out_ready toggled 1,0,0,1,… → each field held stable while stalled. No byte lost or duplicated; exactly 6 transfers.
- memory_in changed to all zeros the cycle after start → streamed bytes match the original snapshot.
- p1_money=00, p2_money=0A → broke=2'b01 from LOAD onward, held after done until the next start.
- Reset asserted after the 3rd transfer → out_valid=0, busy=0 immediately, no done pulse. A new start then streams from index 0.

Source files
------------

// File: rtl/memory_field_reader_pkg.sv
// Shared layout of the 48-bit game memory word and field tag codes,
// used by the packer, this reader and the transaction checker.
package memory_field_reader_pkg;

    localparam int unsigned FIELD_W = 8;
    localparam int unsigned MEM_W   = 48;

    localparam logic [1:0] FIELD_PRIVATE = 2'd0;
    localparam logic [1:0] FIELD_PUBLIC  = 2'd1;
    localparam logic [1:0] FIELD_MONEY   = 2'd2;

    localparam int unsigned P1_PRIVATE_LSB = 40;
    localparam int unsigned P1_PUBLIC_LSB  = 32;
    localparam int unsigned P1_MONEY_LSB   = 24;
    localparam int unsigned P2_PRIVATE_LSB = 16;
    localparam int unsigned P2_PUBLIC_LSB  = 8;
    localparam int unsigned P2_MONEY_LSB   = 0;

    typedef struct packed {
        logic [FIELD_W-1:0] data;
        logic               player;
        logic [1:0]         field;
        logic               last;
    } field_beat_t;

    function automatic logic [FIELD_W-1:0] get_byte(input logic [MEM_W-1:0] mem,
                                                    input int unsigned     lsb);
        return mem[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/memory_field_reader_field_select.sv
// Combinational field mux: snapshot + index + hide flag to one tagged beat.
module field_select
    import memory_field_reader_pkg::*;
#(
    parameter logic [7:0] HIDE_VALUE = 8'h00
) (
    input  logic [47:0]  snapshot,
    input  logic [2:0]   index,
    input  logic         hide,
    output field_beat_t  beat
);

    always_comb begin
        beat = '0;
        unique case (index)
            3'd0: begin beat.data = get_byte(snapshot, P1_PRIVATE_LSB); beat.player = 1'b0; beat.field = FIELD_PRIVATE; end
            3'd1: begin beat.data = get_byte(snapshot, P1_PUBLIC_LSB);  beat.player = 1'b0; beat.field = FIELD_PUBLIC;  end
            3'd2: begin beat.data = get_byte(snapshot, P1_MONEY_LSB);   beat.player = 1'b0; beat.field = FIELD_MONEY;   end
            3'd3: begin beat.data = get_byte(snapshot, P2_PRIVATE_LSB); beat.player = 1'b1; beat.field = FIELD_PRIVATE; end
            3'd4: begin beat.data = get_byte(snapshot, P2_PUBLIC_LSB);  beat.player = 1'b1; beat.field = FIELD_PUBLIC;  end
            3'd5: begin beat.data = get_byte(snapshot, P2_MONEY_LSB);   beat.player = 1'b1; beat.field = FIELD_MONEY;   end
            default: beat = '0;
        endcase
        if (hide && beat.field == FIELD_PRIVATE) begin
            beat.data = HIDE_VALUE;
        end
        beat.last = (index == 3'd5);
    end

endmodule

// File: rtl/memory_field_reader.sv
// Snapshots the 48-bit game memory word and streams it out as six tagged
// bytes over valid/ready, flagging any player whose balance is zero.
module memory_field_reader
    import memory_field_reader_pkg::*;
#(
    parameter int         NUM_FIELDS = 6,
    parameter logic [7:0] HIDE_VALUE = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] memory_in,
    input  logic        start,
    input  logic        hide_private,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_player,
    output logic [1:0]  out_field,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  broke
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [2:0] LAST_IDX = 3'(NUM_FIELDS - 1);

    logic [1:0]  state;
    logic [47:0] snapshot;
    logic        hide_q;
    logic [2:0]  index;
    logic [2:0]  sel_index;
    field_beat_t beat;

    // LOAD presents field 0; in SEND the mux looks one field ahead so the
    // next beat is registered on the same edge that accepts the current one.
    assign sel_index = (state == SEND) ? index + 3'd1 : index;

    field_select #(.HIDE_VALUE(HIDE_VALUE)) u_field_select (
        .snapshot (snapshot),
        .index    (sel_index),
        .hide     (hide_q),
        .beat     (beat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snapshot   <= '0;
            hide_q     <= 1'b0;
            index      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_player <= 1'b0;
            out_field  <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            broke      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= memory_in;
                        hide_q   <= hide_private;
                        index    <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    broke      <= {get_byte(snapshot, P2_MONEY_LSB) == 8'h00,
                                   get_byte(snapshot, P1_MONEY_LSB) == 8'h00};
                    out_data   <= beat.data;
                    out_player <= beat.player;
                    out_field  <= beat.field;
                    out_last   <= beat.last;
                    out_valid  <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (index == LAST_IDX) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            index      <= index + 3'd1;
                            out_data   <= beat.data;
                            out_player <= beat.player;
                            out_field  <= beat.field;
                            out_last   <= beat.last;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
